// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for the async FIFO: issues credit-limited reads, absorbs the read
// latency in a small circular buffer and presents the words as a valid/ready stream.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + RD_LATENCY + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);
    localparam logic [OW-1:0] DEPTH_OW = OW'(BUF_DEPTH);

    logic [RD_LATENCY-1:0] inflight;
    logic [RD_LATENCY-1:0] inflight_next;
    logic [OW-1:0]         occ;
    logic [OW-1:0]         inflight_count;
    logic [OW-1:0]         pending;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [DATA_WIDTH-1:0] entry [BUF_DEPTH];
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so the accumulation reads in order and no latch is inferred.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_count = inflight_count + OW'(inflight[i]);
        end
    end

    always_comb begin
        inflight_next    = inflight << 1;
        inflight_next[0] = fifo_rd_en;
    end

    assign push    = inflight[RD_LATENCY-1];
    assign pop     = m_valid & m_ready;
    assign pending = occ + inflight_count;

    // A word popped this cycle frees its slot immediately, hence the m_ready -> rd_en path.
    assign fifo_rd_en = !rd_rst && enable && !fifo_empty && ((pending - OW'(pop)) < DEPTH_OW);

    assign m_valid = (occ != '0);
    assign m_data  = entry[head];
    assign idle    = (occ == '0) && (inflight == '0);

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    // The buffer entries are reset as well, so m_data reads zero straight out of reset.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight   <= '0;
            occ        <= '0;
            head       <= '0;
            tail       <= '0;
            word_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            inflight <= inflight_next;
            if (push) begin
                entry[tail] <= fifo_rd_data;
                tail        <= wrap_inc(tail);
            end
            if (pop) begin
                head <= wrap_inc(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
            if (pop && (word_count != '1)) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: behavioural FIFO on the read side, a
// stream log on the output side, and a second instance with a 4-bit word counter.
module tb_fifo_rd_stream_adapter;

    logic        rd_clk     = 1'b0;
    logic        rd_rst     = 1'b1;
    logic        enable     = 1'b1;
    logic        m_ready    = 1'b1;
    logic        hold_empty = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_en, fifo_rd_en_c4;
    logic        m_valid, m_valid_c4;
    logic [7:0]  m_data, m_data_c4;
    logic        idle, idle_c4;
    logic [15:0] word_count;
    logic [3:0]  word_count_c4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fmem [256];
    logic [7:0] omem [256];
    int wr_ptr     = 0;
    int rd_ptr     = 0;
    int out_cnt    = 0;
    int rd_pulses  = 0;
    int empty_viol = 0;

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    fifo_rd_stream_adapter dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .idle(idle), .word_count(word_count)
    );

    fifo_rd_stream_adapter #(.CNT_WIDTH(4)) dut_c4 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en_c4), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid_c4),
        .m_ready(m_ready), .m_data(m_data_c4), .idle(idle_c4), .word_count(word_count_c4)
    );

    // FIFO model with one cycle read latency, plus the output stream log.
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
            rd_pulses    <= rd_pulses + 1;
        end
        if (fifo_rd_en && fifo_empty) empty_viol <= empty_viol + 1;
        if (m_valid && m_ready) begin
            omem[out_cnt[7:0]] <= m_data;
            out_cnt            <= out_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr[7:0]] = base + 8'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (out_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_out", 32'(out_cnt >= target), 32'd1);
    endtask

    int rp, oc;

    initial begin
        // 1: reset holds everything off even with data available
        load(16, 8'h01);
        repeat (3) tick();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h00);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);

        // 2: streaming with m_ready=1; first read right after release
        tick();
        rd_rst = 1'b0;
        settle();
        check("first_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        check("lat_t1_valid", 32'(m_valid), 32'd0);
        tick();
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("stream_valid_%0d", i), 32'(m_valid), 32'd1);
            check($sformatf("stream_data_%0d", i), 32'(m_data), 32'(i));
            tick();
        end
        check("stream_end_valid", 32'(m_valid), 32'd0);
        check("stream_end_idle", 32'(idle), 32'd1);
        check("stream_wc", 32'(word_count), 32'd16);
        check("stream_wc_c4_sat", 32'(word_count_c4), 32'd15);
        check("stream_rd_pulses", 32'(rd_pulses), 32'd16);

        // 3: back-pressure: only buffer credit worth of reads, head held stable
        m_ready = 1'b0;
        load(16, 8'h01);
        rp = rd_pulses;
        repeat (10) tick();
        check("bp_rd_pulses", 32'(rd_pulses - rp), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'h01);
        repeat (5) tick();
        check("bp_hold_valid", 32'(m_valid), 32'd1);
        check("bp_hold_data", 32'(m_data), 32'h01);
        oc = out_cnt;
        m_ready = 1'b1;
        wait_out(oc + 16, 60);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("bp_order_%0d", i), 32'(omem[(oc + i) % 256]), 32'(i + 1));
        end
        repeat (3) tick();
        check("bp_count", 32'(out_cnt - oc), 32'd16);
        check("bp_wc", 32'(word_count), 32'd32);

        // 4: FIFO empty with one word buffered
        m_ready = 1'b0;
        load(1, 8'hA5);
        repeat (5) tick();
        check("one_valid", 32'(m_valid), 32'd1);
        check("one_data", 32'(m_data), 32'hA5);
        check("one_idle", 32'(idle), 32'd0);
        rp = rd_pulses;
        oc = out_cnt;
        m_ready = 1'b1;
        repeat (50) tick();
        check("empty_rd_pulses", 32'(rd_pulses - rp), 32'd0);
        check("empty_delivered", 32'(out_cnt - oc), 32'd1);
        check("empty_valid", 32'(m_valid), 32'd0);
        check("empty_idle", 32'(idle), 32'd1);

        // fifo_empty forced high while the FIFO model holds data
        hold_empty = 1'b1;
        load(4, 8'h31);
        rp = rd_pulses;
        repeat (20) tick();
        check("hold_empty_rd_pulses", 32'(rd_pulses - rp), 32'd0);

        // 5: enable dropped the cycle after a read
        oc = out_cnt;
        hold_empty = 1'b0;
        settle();
        check("en_read", 32'(fifo_rd_en), 32'd1);
        tick();
        enable = 1'b0;
        settle();
        check("en_off_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (10) tick();
        check("en_off_rd_pulses", 32'(rd_pulses - rp), 32'd1);
        check("en_off_delivered", 32'(out_cnt - oc), 32'd1);
        check("en_off_word", 32'(omem[oc % 256]), 32'h31);
        check("en_off_idle", 32'(idle), 32'd1);
        enable = 1'b1;
        wait_out(oc + 4, 30);
        check("en_on_last_word", 32'(omem[(oc + 3) % 256]), 32'h34);

        // 6: counter saturation on the 4-bit instance, then reset with a read in flight
        tick();
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
        settle();
        check("rerst_wc", 32'(word_count), 32'd0);
        check("rerst_wc_c4", 32'(word_count_c4), 32'd0);
        oc = out_cnt;
        load(20, 8'h40);
        wait_out(oc + 20, 60);
        repeat (3) tick();
        check("sat_wc", 32'(word_count), 32'd20);
        check("sat_wc_c4", 32'(word_count_c4), 32'd15);
        check("sat_last_word", 32'(omem[(oc + 19) % 256]), 32'h53);
        load(1, 8'h77);
        settle();
        check("flight_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        check("flight_idle", 32'(idle), 32'd0);
        rd_rst = 1'b1;
        settle();
        check("flight_rst_idle", 32'(idle), 32'd1);
        check("flight_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("flight_rst_wc", 32'(word_count), 32'd0);
        check("flight_rst_wc_c4", 32'(word_count_c4), 32'd0);
        tick();
        rd_rst = 1'b0;
        oc = out_cnt;
        repeat (10) tick();
        check("flight_lost", 32'(out_cnt - oc), 32'd0);
        check("flight_valid", 32'(m_valid), 32'd0);
        check("flight_wc", 32'(word_count), 32'd0);

        check("rd_en_while_empty", 32'(empty_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
